// File: rtl/mtr_pkg.sv
// mtr_pkg: shared types and speed-to-duty conversion for the mtr_drv slice (MTR_BRAKE_EN enables braking).
package mtr_pkg;
    typedef logic signed [10:0] spd_t;
    typedef logic [10:0] duty_t;
    localparam int PWM_W = 11;
    localparam duty_t DUTY_ZERO = 11'h400;
    function automatic duty_t spd2duty(input spd_t spd);
        return {~spd[10], spd[9:0]};
    endfunction
endpackage

// File: rtl/mtr_pwm_side.sv
// mtr_pwm_side: one H-bridge side -- shadow duty, dead-time compares, registered gate drives;
// MTR_BRAKE_EN adds brake handling with per-side low-time counters.
module mtr_pwm_side
    import mtr_pkg::*;
#(
    parameter logic [PWM_W-1:0] NONOVERLAP = 11'd32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] i_cnt,
    input  spd_t             i_spd,
`ifdef MTR_BRAKE_EN
    input  logic             i_brake,
`endif
    output logic             o_pwm1,
    output logic             o_pwm2
);
    duty_t r_duty;
    logic  w_cmp1, w_cmp2, w_pwm1_d, w_pwm2_d;
    assign w_cmp1 = (i_cnt >= NONOVERLAP) && (i_cnt < r_duty);
    assign w_cmp2 = {1'b0, i_cnt} >= ({1'b0, r_duty} + {1'b0, NONOVERLAP});
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_duty <= DUTY_ZERO;
        else if (&i_cnt) r_duty <= spd2duty(i_spd);
`ifdef MTR_BRAKE_EN
    logic [PWM_W-1:0] r_lo1, r_lo2, w_lo1_nx, w_lo2_nx;
    logic             r_brk, r_hold;
    // saturating low-time counters: a gate may only rise once its partner has been low NONOVERLAP clks
    assign w_lo1_nx = o_pwm1 ? '0 : (r_lo1 == NONOVERLAP) ? r_lo1 : r_lo1 + 1'b1;
    assign w_lo2_nx = o_pwm2 ? '0 : (r_lo2 == NONOVERLAP) ? r_lo2 : r_lo2 + 1'b1;
    assign w_pwm1_d = !i_brake && w_cmp1 && (w_lo2_nx >= NONOVERLAP);
    assign w_pwm2_d = (i_brake || (w_cmp2 && !r_hold && !r_brk)) && (w_lo1_nx >= NONOVERLAP);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_lo1  <= '0;
            r_lo2  <= '0;
            r_brk  <= 1'b0;
            r_hold <= 1'b0;
        end else begin
            r_lo1  <= w_lo1_nx;
            r_lo2  <= w_lo2_nx;
            r_brk  <= i_brake;
            r_hold <= !(&i_cnt) && (r_hold || (r_brk && !i_brake));
        end
`else
    assign w_pwm1_d = w_cmp1;
    assign w_pwm2_d = w_cmp2;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            o_pwm1 <= 1'b0;
            o_pwm2 <= 1'b0;
        end else begin
            o_pwm1 <= w_pwm1_d;
            o_pwm2 <= w_pwm2_d;
        end
endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM drive with a shared 2048-clk period counter;
// define MTR_BRAKE_EN to add the brake input.
module mtr_drv
    import mtr_pkg::*;
#(
    parameter logic [PWM_W-1:0] NONOVERLAP = 11'd32
) (
    input  logic clk,
    input  logic rst_n,
    input  spd_t lft_spd,
    input  spd_t rght_spd,
`ifdef MTR_BRAKE_EN
    input  logic brake,
`endif
    output logic lftPWM1,
    output logic lftPWM2,
    output logic rghtPWM1,
    output logic rghtPWM2,
    output logic prd_strt
);
    logic [PWM_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cnt    <= '0;
            prd_strt <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            prd_strt <= &r_cnt;
        end
    mtr_pwm_side #(.NONOVERLAP(NONOVERLAP)) u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cnt  (r_cnt),
        .i_spd  (lft_spd),
`ifdef MTR_BRAKE_EN
        .i_brake(brake),
`endif
        .o_pwm1 (lftPWM1),
        .o_pwm2 (lftPWM2)
    );
    mtr_pwm_side #(.NONOVERLAP(NONOVERLAP)) u_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cnt  (r_cnt),
        .i_spd  (rght_spd),
`ifdef MTR_BRAKE_EN
        .i_brake(brake),
`endif
        .o_pwm1 (rghtPWM1),
        .o_pwm2 (rghtPWM2)
    );
endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: table-driven period measurements plus hand-written mid-period, reset and brake sequences.
module tb_mtr_drv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] lft_spd = 11'h000;
    logic [10:0] rght_spd = 11'h000;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;
`ifdef MTR_BRAKE_EN
    logic        brake = 1'b0;
`endif
    int n_chk = 0, n_pass = 0, ov_total = 0;
    int m_l1, m_l2, m_r1, m_r2, m_f1, m_f2, m_ov;

    always #5 clk = ~clk;

    mtr_drv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
`ifdef MTR_BRAKE_EN
        .brake   (brake),
`endif
        .lftPWM1 (lftPWM1),
        .lftPWM2 (lftPWM2),
        .rghtPWM1(rghtPWM1),
        .rghtPWM2(rghtPWM2),
        .prd_strt(prd_strt)
    );

    always @(negedge clk)
        if ((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)) ov_total++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [10:0] lft, rght;
        int          l1, l2, r1, r2, f1, f2;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic sync();
        int k = 0;
        while (prd_strt && k < 4200) begin @(negedge clk); k++; end
        while (!prd_strt && k < 4200) begin @(negedge clk); k++; end
        if (!prd_strt) begin
            n_chk++;
            $display("FAIL sync: prd_strt not seen within %0d clks", k);
        end
    endtask

    // entered at the negedge of the cnt==0 cycle; sample i reflects the compare made at cnt==i
    task automatic run_window(input int chg, input logic [10:0] nl);
        m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0; m_f1 = -1; m_f2 = -1; m_ov = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            m_l1 += int'(lftPWM1);
            m_l2 += int'(lftPWM2);
            m_r1 += int'(rghtPWM1);
            m_r2 += int'(rghtPWM2);
            if (lftPWM1 && m_f1 < 0) m_f1 = i;
            if (lftPWM2 && m_f2 < 0) m_f2 = i;
            if ((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)) m_ov++;
            if (i == chg) lft_spd = nl;
        end
    endtask

    initial begin
        vecs[0] = '{11'h000, 11'h3FF, 992, 992, 2015, 0, 32, 1056};
        vecs[1] = '{11'h400, 11'h000, 0, 2016, 992, 992, -1, 32};
        vecs[2] = '{11'h200, 11'h7E0, 1504, 480, 960, 1024, 32, 1568};
        vecs[3] = '{11'h420, 11'h3DF, 0, 1984, 1983, 1, -1, 64};
        vecs[4] = '{11'h421, 11'h3E0, 1, 1983, 1984, 0, 32, 65};
        #1;
        check("reset_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt}), 0);
        repeat (3) @(negedge clk);
        check("reset_hold", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt}), 0);
        rst_n = 1'b1;
        foreach (vecs[v]) begin
            lft_spd  = vecs[v].lft;
            rght_spd = vecs[v].rght;
            sync();
            run_window(-1, 11'h000);
            check($sformatf("v%0d_lft1_high", v), m_l1, vecs[v].l1);
            check($sformatf("v%0d_lft2_high", v), m_l2, vecs[v].l2);
            check($sformatf("v%0d_rght1_high", v), m_r1, vecs[v].r1);
            check($sformatf("v%0d_rght2_high", v), m_r2, vecs[v].r2);
            check($sformatf("v%0d_lft1_rise", v), m_f1, vecs[v].f1);
            check($sformatf("v%0d_lft2_rise", v), m_f2, vecs[v].f2);
            check($sformatf("v%0d_overlap", v), m_ov, 0);
        end
        // mid-period command change only takes effect next period
        lft_spd = 11'h000;
        rght_spd = 11'h000;
        sync();
        run_window(599, 11'h200);
        check("mid_cur_lft1", m_l1, 992);
        run_window(-1, 11'h000);
        check("mid_next_lft1", m_l1, 1504);
        check("mid_next_lft2", m_l2, 480);
        // asynchronous reset in the middle of a period
        lft_spd = 11'h200;
        rght_spd = 11'h3FF;
        sync();
        repeat (1200) @(negedge clk);
        check("pre_rst_pwm1", int'({lftPWM1, rghtPWM1}), 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_window(-1, 11'h000);
        check("post_rst_lft1", m_l1, 992);
        check("post_rst_lft2", m_l2, 992);
        check("post_rst_rght1", m_r1, 992);
        check("post_rst_rght2", m_r2, 992);
        check("post_rst_lft1_rise", m_f1, 32);
        check("post_rst_prd_strt", int'(prd_strt), 1);
        @(negedge clk);
        check("prd_strt_pulse", int'(prd_strt), 0);
`ifdef MTR_BRAKE_EN
        begin
            int k;
            lft_spd = 11'h000;
            rght_spd = 11'h000;
            sync();
            sync();
            repeat (200) @(negedge clk);
            check("brk_pre_pwm1", int'({lftPWM1, rghtPWM1}), 3);
            brake = 1'b1;
            @(negedge clk);
            check("brk_pwm1_off", int'({lftPWM1, rghtPWM1}), 0);
            k = 0;
            while (!lftPWM2 && k < 100) begin @(negedge clk); k++; end
            check("brk_pwm2_delay", k, 32);
            check("brk_rght_pwm2", int'(rghtPWM2), 1);
            repeat (50) @(negedge clk);
            brake = 1'b0;
            @(negedge clk);
            check("unbrk_pwm2_off", int'({lftPWM2, rghtPWM2}), 0);
            k = 0;
            while (!lftPWM1 && k < 2100) begin @(negedge clk); k++; end
            check("unbrk_pwm1_hold", int'(k >= 32), 1);
            check("unbrk_pwm1_back", int'(lftPWM1), 1);
        end
`endif
        check("no_overlap_total", ov_total, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
